// File: rtl/da2dac.sv
// da2dac - serializer for the PmodDA2 (two DAC121S101 chips).
//
// Accepts one 12-bit sample plus a 2-bit power-down command over the
// dacdav/davdac four-phase handshake. It then shifts the 16-bit frame
// {2'b00, cmd, data} out MSB first on the shared SYNC/SCLK lines and on
// the per-chip data lines. SCLK is derived from dacclk by a divider of
// 2*HALFDIV and idles high. Data changes only while SCLK is high, and the
// DACs sample on the falling edge.
//
// Optional build macro: DA2_MIRROR_EN
//   defined     : dac1d follows dac0d, so both chips output the same sample.
//   not defined : chip 1 gets {2'b00, 2'b11, 12'h000} (high-impedance
//                 power-down) during every frame and is held low between
//                 frames.
module da2dac #(
  parameter int HALFDIV = 1,
  parameter int GAP     = 2
) (
  input  logic        dacclk,
  input  logic        resetn,
  input  logic        dacdav,
  output logic        davdac,
  input  logic [11:0] dacdata,
  input  logic [1:0]  daccmd,
  output logic        dacsck,
  output logic        dacsync,
  output logic        dac0d,
  output logic        dac1d
);

  // Divider counts 0..HALFDIV-1. The gap counter counts GAP SCLK periods
  // of idle time with SYNC high.
  localparam int GAPCYC = GAP * 2 * HALFDIV;
  localparam int DW     = (HALFDIV > 1) ? $clog2(HALFDIV) : 1;
  localparam int GW     = (GAPCYC > 1) ? $clog2(GAPCYC) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(HALFDIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAPCYC - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

  state_t        state_r, state_s;
  logic [DW-1:0] div_r,   div_s;
  logic [GW-1:0] gap_r,   gap_s;
  logic [3:0]    bit_r,   bit_s;
  logic [15:0]   word_r,  word_s;
  logic          sck_r,   sck_s;
  logic          sync_r,  sync_s;
  logic          ack_r,   ack_s;
  logic          d0_r,    d0_s;
  logic          d1_r,    d1_s;

  // Next-state logic: handshake, SCLK divider, bit counter and frame sequencing.
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    gap_s   = gap_r;
    bit_s   = bit_r;
    word_s  = word_r;
    sck_s   = sck_r;
    sync_s  = sync_r;

    // The acknowledge clears on the first cycle the request is seen low,
    // whatever the frame sequencer is doing.
    if (dacdav == 1'b0) begin
      ack_s = 1'b0;
    end else begin
      ack_s = ack_r;
    end

    case (state_r)
      ST_IDLE: begin
        sck_s  = 1'b1;
        sync_s = 1'b1;
        div_s  = '0;
        gap_s  = '0;
        // A request is new only when the previous one has been released
        // (ack low). A request held high therefore cannot retrigger a frame.
        if ((dacdav == 1'b1) && (ack_r == 1'b0)) begin
          word_s  = {2'b00, daccmd, dacdata};
          bit_s   = 4'd15;
          ack_s   = 1'b1;
          sync_s  = 1'b0;
          state_s = ST_SHIFT;
        end else begin
          bit_s   = 4'd0;
        end
      end

      ST_SHIFT: begin
        gap_s = '0;
        if (div_r == DIV_LAST) begin
          div_s = '0;
          sck_s = ~sck_r;
          if (sck_r == 1'b0) begin
            // This is a rising SCLK edge. It ends the current bit: advance,
            // or close the frame after bit 0.
            if (bit_r == 4'd0) begin
              sync_s  = 1'b1;
              state_s = ST_WAIT;
            end else begin
              bit_s   = bit_r - 4'd1;
            end
          end else begin
            // Falling edge: the DACs sample here, so the data stays put.
            bit_s = bit_r;
          end
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end

      ST_WAIT: begin
        sck_s  = 1'b1;
        sync_s = 1'b1;
        div_s  = '0;
        if (gap_r == GAP_LAST) begin
          gap_s   = '0;
          state_s = ST_IDLE;
        end else begin
          gap_s   = gap_r + GAP_ONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
        sck_s   = 1'b1;
        sync_s  = 1'b1;
        div_s   = '0;
        gap_s   = '0;
        bit_s   = 4'd0;
      end
    endcase
  end

  // Chip 0 data: the bit selected by the next bit counter while the frame is open, low otherwise.
  always_comb begin
    if (sync_s == 1'b0) begin
      d0_s = word_s[bit_s];
    end else begin
      d0_s = 1'b0;
    end
  end

`ifdef DA2_MIRROR_EN
  // Chip 1 carries exactly the same serial stream as chip 0.
  always_comb begin
    d1_s = d0_s;
  end
`else
  localparam logic [15:0] PD_WORD = 16'h3000;

  // Chip 1 shifts the high-impedance power-down word in step with chip 0; low between frames.
  always_comb begin
    if (sync_s == 1'b0) begin
      d1_s = PD_WORD[bit_s];
    end else begin
      d1_s = 1'b0;
    end
  end
`endif

  // State and output registers. Reset forces the idle line levels immediately.
  always_ff @(posedge dacclk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      div_r   <= '0;
      gap_r   <= '0;
      bit_r   <= 4'd0;
      word_r  <= 16'h0000;
      sck_r   <= 1'b1;
      sync_r  <= 1'b1;
      ack_r   <= 1'b0;
      d0_r    <= 1'b0;
      d1_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      gap_r   <= gap_s;
      bit_r   <= bit_s;
      word_r  <= word_s;
      sck_r   <= sck_s;
      sync_r  <= sync_s;
      ack_r   <= ack_s;
      d0_r    <= d0_s;
      d1_r    <= d1_s;
    end
  end

  assign davdac  = ack_r;
  assign dacsck  = sck_r;
  assign dacsync = sync_r;
  assign dac0d   = d0_r;
  assign dac1d   = d1_r;

endmodule

// File: tb/tb_da2dac.sv
// tb_da2dac - self-checking bench for da2dac.
// DUT a uses the default parameters (HALFDIV=1, GAP=2). DUT b uses HALFDIV=3.
// Expected frames come from the frame rule {2'b00, cmd, data}. Expected
// timing comes from 32*HALFDIV low time and a 32*H + 2*GAP*H + 1 cycle
// minimum accept-to-accept interval.
module tb_da2dac;

  localparam int A_H = 1;
  localparam int A_G = 2;
  localparam int B_H = 3;
  localparam int B_G = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rstn, a_dav, a_ack, a_sck, a_sync, a_d0, a_d1;
  logic [11:0] a_data;
  logic [1:0]  a_cmd;
  logic        b_rstn, b_dav, b_ack, b_sck, b_sync, b_d0, b_d1;
  logic [11:0] b_data;
  logic [1:0]  b_cmd;

  da2dac #(.HALFDIV(A_H), .GAP(A_G)) dut_a (
    .dacclk(clk), .resetn(a_rstn), .dacdav(a_dav), .davdac(a_ack),
    .dacdata(a_data), .daccmd(a_cmd), .dacsck(a_sck), .dacsync(a_sync),
    .dac0d(a_d0), .dac1d(a_d1)
  );

  da2dac #(.HALFDIV(B_H), .GAP(B_G)) dut_b (
    .dacclk(clk), .resetn(b_rstn), .dacdav(b_dav), .davdac(b_ack),
    .dacdata(b_data), .daccmd(b_cmd), .dacsck(b_sck), .dacsync(b_sync),
    .dac0d(b_d0), .dac1d(b_d1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame word seen by each chip.
  function automatic logic [15:0] frame_word(input logic [1:0] c, input logic [11:0] d);
    return {2'b00, c, d};
  endfunction

  function automatic logic [15:0] chip1_word(input logic [15:0] w);
`ifdef DA2_MIRROR_EN
    return w;
`else
    return 16'h3000;
`endif
  endfunction

  // Monitor for DUT a: frames captured on falling SCLK while SYNC is low.
  int          a_cycle = 0;
  int          a_starts = 0;
  int          a_sck_falls = 0;
  int          a_bad1 = 0;
  int          a_low = 0;
  int          a_nbits = 0;
  logic        a_psck = 1'b1;
  logic        a_psync = 1'b1;
  logic [15:0] a_cap0 = 16'h0;
  logic [15:0] a_cap1 = 16'h0;
  logic [15:0] a_q0[$];
  logic [15:0] a_q1[$];
  int          a_qlow[$];
  int          a_qn[$];
  int          a_qst[$];
  int          a_qrise[$];

  always @(negedge clk) begin
    a_cycle = a_cycle + 1;
    if (a_psync && !a_sync) begin
      a_cap0 = 16'h0; a_cap1 = 16'h0; a_nbits = 0; a_low = 0;
      a_starts = a_starts + 1;
      a_qst.push_back(a_cycle);
    end
    if (!a_sync) begin
      a_low = a_low + 1;
      if (a_psck && !a_sck) begin
        a_cap0 = {a_cap0[14:0], a_d0};
        a_cap1 = {a_cap1[14:0], a_d1};
        a_nbits = a_nbits + 1;
      end
    end
    if (a_psck && !a_sck) a_sck_falls = a_sck_falls + 1;
    if (!a_psync && a_sync) begin
      a_q0.push_back(a_cap0); a_q1.push_back(a_cap1);
      a_qlow.push_back(a_low); a_qn.push_back(a_nbits);
      a_qrise.push_back(a_cycle);
    end
`ifdef DA2_MIRROR_EN
    if (a_d1 !== a_d0) a_bad1 = a_bad1 + 1;
`else
    if (a_sync && (a_d1 !== 1'b0)) a_bad1 = a_bad1 + 1;
`endif
    a_psck = a_sck;
    a_psync = a_sync;
  end

  task automatic clear_a_queues();
    a_q0.delete(); a_q1.delete(); a_qlow.delete(); a_qn.delete();
    a_qst.delete(); a_qrise.delete();
  endtask

  // Request a frame on DUT a. Once it is acknowledged, change the inputs and release the request.
  task automatic send_a(input logic [11:0] d, input logic [1:0] c, input logic [11:0] d_after);
    int  n0;
    bit  ok;
    n0 = a_q0.size();
    a_data = d; a_cmd = c; a_dav = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (a_ack === 1'b1) ok = 1'b1;
    end
    chk("send_ack_seen", 32'(ok), 32'd1);
    a_data = d_after; a_cmd = ~c; a_dav = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (a_q0.size() > n0) ok = 1'b1;
    end
    chk("send_frame_done", 32'(ok), 32'd1);
  endtask

  task automatic check_a_frame(input string tag, input logic [15:0] w, output int st, output int rs);
    st = -1; rs = -1;
    chk({tag, "_present"}, 32'(a_q0.size() > 0), 32'd1);
    if (a_q0.size() > 0) begin
      chk({tag, "_d0"},    32'(a_q0.pop_front()), 32'(w));
      chk({tag, "_d1"},    32'(a_q1.pop_front()), 32'(chip1_word(w)));
      chk({tag, "_low"},   32'(a_qlow.pop_front()), 32'(32 * A_H));
      chk({tag, "_nbits"}, 32'(a_qn.pop_front()), 32'd16);
      st = a_qst.pop_front();
      rs = a_qrise.pop_front();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st1, rs1, st2, rs2, s0, f0, low, nb, f1, per;
    bit          ok, done;
    logic        ps;
    logic [15:0] cap0, cap1, w;
    logic [11:0] rd;
    logic [1:0]  rc;

    a_rstn = 1'b0; a_dav = 1'b0; a_data = 12'h0; a_cmd = 2'b00;
    b_rstn = 1'b0; b_dav = 1'b0; b_data = 12'h0; b_cmd = 2'b00;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_ack",  32'(a_ack),  32'd0);
    chk("rst_sck",  32'(a_sck),  32'd1);
    chk("rst_sync", 32'(a_sync), 32'd1);
    chk("rst_d0",   32'(a_d0),   32'd0);
    chk("rst_d1",   32'(a_d1),   32'd0);
    a_rstn = 1'b1; b_rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_sync", 32'(a_sync), 32'd1);

    // First frame 0A5C: acknowledge, SYNC low and bit 15 one cycle after the request.
    a_data = 12'hA5C; a_cmd = 2'b00; a_dav = 1'b1;
    @(negedge clk);
    chk("t1_ack_1cyc",  32'(a_ack),  32'd1);
    chk("t1_sync_low",  32'(a_sync), 32'd0);
    chk("t1_bit15",     32'(a_d0),   32'd0);
    a_dav = 1'b0;
    @(negedge clk);
    chk("t1_ack_drop",  32'(a_ack),  32'd0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (a_q0.size() > 0) ok = 1'b1;
    end
    chk("t1_done", 32'(ok), 32'd1);
    check_a_frame("t1", frame_word(2'b00, 12'hA5C), st1, rs1);
    repeat (8) @(negedge clk);

    // A request held for 200 cycles sends exactly one frame.
    s0 = a_starts;
    rd = 12'($urandom);
    a_data = rd; a_cmd = 2'b00; a_dav = 1'b1;
    repeat (200) @(negedge clk);
    chk("hold_one_frame", 32'(a_starts - s0), 32'd1);
    chk("hold_ack_held",  32'(a_ack), 32'd1);
    a_dav = 1'b0;
    @(negedge clk);
    chk("hold_ack_drop",  32'(a_ack), 32'd0);
    check_a_frame("hold", frame_word(2'b00, rd), st1, rs1);
    repeat (4) @(negedge clk);

    // Request released and re-raised during SHIFT: the second frame is accepted on the first idle edge.
    rd = 12'($urandom); rc = 2'($urandom);
    a_data = rd; a_cmd = rc; a_dav = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (a_ack === 1'b1) ok = 1'b1;
    end
    chk("b2b_ack", 32'(ok), 32'd1);
    a_dav = 1'b0;
    @(negedge clk);
    chk("b2b_ack_clear_in_shift", 32'(a_ack), 32'd0);
    a_data = ~rd; a_cmd = ~rc; a_dav = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (a_q0.size() >= 2) ok = 1'b1;
    end
    chk("b2b_two_frames", 32'(ok), 32'd1);
    a_dav = 1'b0;
    check_a_frame("b2b_f1", frame_word(rc, rd), st1, rs1);
    check_a_frame("b2b_f2", frame_word(~rc, ~rd), st2, rs2);
    chk("b2b_interval", 32'(st2 - st1), 32'(32 * A_H + 2 * A_G * A_H + 1));
    chk("b2b_gap",      32'(st2 - rs1), 32'(2 * A_G * A_H + 1));
    repeat (8) @(negedge clk);

    // Inputs change mid-frame: the latched word is transmitted.
    send_a(12'h800, 2'b00, 12'h001);
    check_a_frame("latch", 16'h0800, st1, rs1);
    send_a(12'h123, 2'b00, 12'h000);
    check_a_frame("w123", 16'h0123, st1, rs1);

    // Random frames.
    for (int k = 0; k < 6; k++) begin
      rd = 12'($urandom); rc = 2'($urandom_range(3, 0));
      send_a(rd, rc, 12'($urandom));
      w = frame_word(rc, rd);
      check_a_frame("rand", w, st1, rs1);
    end

    // Reset pulse at bit 7: the lines go idle immediately, and nothing happens until a new request.
    a_data = 12'h5A5; a_cmd = 2'b00; a_dav = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (a_sync === 1'b0) ok = 1'b1;
    end
    chk("rstmid_start", 32'(ok), 32'd1);
    a_dav = 1'b0;
    repeat (16) @(negedge clk);
    #2 a_rstn = 1'b0;
    #1;
    chk("rstmid_sync", 32'(a_sync), 32'd1);
    chk("rstmid_sck",  32'(a_sck),  32'd1);
    chk("rstmid_d0",   32'(a_d0),   32'd0);
    chk("rstmid_ack",  32'(a_ack),  32'd0);
    @(negedge clk);
    a_rstn = 1'b1;
    repeat (2) @(negedge clk);
    clear_a_queues();
    s0 = a_starts; f0 = a_sck_falls;
    repeat (20) @(negedge clk);
    chk("rstmid_no_frame", 32'(a_starts - s0),    32'd0);
    chk("rstmid_no_sck",   32'(a_sck_falls - f0), 32'd0);
    send_a(12'h3C7, 2'b10, 12'h000);
    check_a_frame("rstmid_next", frame_word(2'b10, 12'h3C7), st1, rs1);
    chk("d1_rule", 32'(a_bad1), 32'd0);

    // DUT b (HALFDIV=3): frame 1FFF, SCLK period 6 cycles, SYNC low 96 cycles.
    b_data = 12'hFFF; b_cmd = 2'b01; b_dav = 1'b1;
    @(negedge clk);
    chk("b_ack_1cyc", 32'(b_ack),  32'd1);
    chk("b_sync_low", 32'(b_sync), 32'd0);
    b_dav = 1'b0;
    low = 0; nb = 0; f1 = -1; per = -1; cap0 = 16'h0; cap1 = 16'h0;
    ps = 1'b1; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!b_sync) begin
        low++;
        if (ps && !b_sck) begin
          cap0 = {cap0[14:0], b_d0};
          cap1 = {cap1[14:0], b_d1};
          nb++;
          if (nb == 1) f1 = i;
          if (nb == 2) per = i - f1;
        end
      end else if (low > 0) begin
        done = 1'b1;
      end else begin
        done = 1'b0;
      end
      ps = b_sck;
      if (!done) @(negedge clk);
    end
    chk("b_done",      32'(done), 32'd1);
    chk("b_frame_d0",  32'(cap0), 32'h1FFF);
    chk("b_frame_d1",  32'(cap1), 32'(chip1_word(16'h1FFF)));
    chk("b_low",       32'(low),  32'(32 * B_H));
    chk("b_nbits",     32'(nb),   32'd16);
    chk("b_first_fall",32'(f1),   32'(B_H));
    chk("b_period",    32'(per),  32'(2 * B_H));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/da2dac.md
# da2dac

Serializer for the PmodDA2 (two DAC121S101 chips) that sits directly downstream of the generator/filter stage in the FIR filter lab. It accepts one 12-bit sample plus a 2-bit power-down command over the existing `dacdav`/`davdac` four-phase handshake. It then shifts a 16-bit frame out on the shared SYNC/SCLK lines and the per-chip data lines. It runs on the 25 MHz system clock and produces the DAC serial clock internally.

## Interface
Parameters:
- `HALFDIV`, 1: SCLK half-period in `dacclk` cycles (≥1); SCLK = dacclk / (2·HALFDIV).
- `GAP`, 2: SYNC-high idle time between frames, in SCLK periods (≥1).

Ports:
- `dacclk`  in  1  system clock, 25 MHz; all logic on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `dacdav`  in  1  upstream data-available request (four-phase).
- `davdac`  out  1  acknowledge to upstream.
- `dacdata`  in  12  sample, unsigned straight binary.
- `daccmd`  in  2  DAC power-down mode (00 = normal operation).
- `dacsck`  out  1  serial clock to both DACs; idles high.
- `dacsync`  out  1  frame sync (SYNC, active-low), shared by both DACs.
- `dac0d`  out  1  serial data to DAC chip 0.
- `dac1d`  out  1  serial data to DAC chip 1.

## Operation
- Frame word: {2'b00, daccmd, dacdata}, shifted MSB first.
- States:
  - IDLE: `dacsync`=1, `dacsck`=1. On `dacdav`=1 with `davdac`=0: latch the frame word into the shift register, set `davdac`=1, go to SHIFT.
  - SHIFT: `dacsync`=0; 16 SCLK periods.
    - Data changes only while `dacsck` is high (at the rising edge, or at frame start).
    - The DAC samples on the falling edge.
    - 4-bit bit counter runs 15→0; after the rising edge that ends bit 0, go to WAIT.
  - WAIT: `dacsync`=1, `dacsck`=1 for GAP·2·HALFDIV cycles, then go to IDLE.
- Handshake:
  - `davdac` drops on the first cycle `dacdav` is sampled low, in any state.
  - A new sample is accepted only in IDLE with `davdac`=0.
  - `dacdav` held high across a whole frame therefore causes no retransmission.
- Input latching: `dacdata`/`daccmd` are captured only on the accepting edge. Upstream changes after that do not affect the frame in flight.
- Divider counter: 0..HALFDIV-1. It wraps to 0 and toggles `dacsck` on terminal count. It is held at 0 outside SHIFT.

## Timing
- Reset values (asynchronous, immediate): `davdac`=0, `dacsck`=1, `dacsync`=1, `dac0d`=0, `dac1d`=0; state IDLE; all counters 0.
- Let `dacdav`=1 be sampled at edge N (IDLE, `davdac`=0):
  - At N+1: `davdac`=1, `dacsync`=0, `dac0d`=bit15.
  - First falling `dacsck` edge at N+1+HALFDIV.
- `dacsync` low for exactly 32·HALFDIV cycles. It rises on the same edge as the final `dacsck` rising edge.
- Minimum accept-to-accept interval: 32·HALFDIV + GAP·2·HALFDIV + 1 cycles; default 37 cycles (≈675 ksps).
- `resetn` asserted mid-frame: outputs go to reset values immediately and the frame is aborted. After release, the next frame starts only on a fresh `dacdav` while in IDLE.
- `dacdav` falling and rising again during SHIFT:
  - `davdac` clears on the fall.
  - The new request is held off until IDLE, then accepted on the first IDLE edge.

## Configuration
- `DA2_MIRROR_EN` defined: `dac1d` equals `dac0d` every cycle, so both chips output the same sample.
- Not defined: chip 1 receives the frame {2'b00, 2'b11, 12'h000} (high-impedance power-down) during every frame, and `dac1d`=0 outside frames.

## Test plan
- Reset, then `dacdav`=1 with `dacdata`=12'hA5C and `daccmd`=00 (default params): capture 16 bits on `dacsck` falling edges = 16'h0A5C. `dacsync` low for 32 cycles, `davdac`=1 one cycle after the request.
- Hold `dacdav`=1 for 200 cycles: exactly one frame is sent. Drop then re-raise `dacdav`: a second frame starts ≥4 cycles after the first `dacsync` rise.
- `daccmd`=2'b01, `dacdata`=12'hFFF, HALFDIV=3: frame = 16'h1FFF, SCLK period 6 cycles, `dacsync` low 96 cycles.
- Pulse `resetn` low at bit 7 of a frame: `dacsync`/`dacsck` go high and `dac0d`=0 asynchronously. No further edges occur until the next request, whose frame is complete and correct.
- Build with and without `DA2_MIRROR_EN` and send 12'h123:
  - Defined: `dac1d` frame = 16'h0123.
  - Not defined: `dac1d` frame = 16'h3000.
- Change `dacdata` from 12'h800 to 12'h001 mid-frame: the transmitted frame remains 16'h0800.
